fp32_divider_seq: RTL and testbench
===================================

// Module: fp32_divider_seq
// PURPOSE
//  Iterative single-precision (IEEE-754 binary32) divider: result = a_operand / b_operand.
//  Counterpart of the combinational FP32 multiplier in the Newton-Raphson datapath; it
//  computes the f(x)/f'(x) step. Restoring mantissa division over multiple cycles,
//  with a valid/ready handshake on both the input and output sides.
// PARAMETERS
//  QBITS_PER_CYCLE  1  quotient bits retired per DIVIDE cycle; legal values 1 or 2
//                      D = 26/QBITS_PER_CYCLE
// PORTS
//  clk        in   1   rising-edge clock; the only clock
//  rst_n      in   1   synchronous, active-low reset
//  in_valid   in   1   operands valid
//  in_ready   out  1   divider idle, can accept operands
//  a_operand  in   32  dividend, FP32
//  b_operand  in   32  divisor, FP32
//  out_valid  out  1   result and flags valid
//  out_ready  in   1   consumer accepts result
//  result     out  32  quotient, FP32
//  Exception  out  1   either operand has exponent 8'hFF
//  Overflow   out  1   final exponent >= 255
//  Underflow  out  1   final exponent <= 0, or quotient unnormalisable
//  DivByZero  out  1   b_operand[30:0]==0 and a is not zero/exception
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state IDLE; in_ready=1; out_valid=0; result=0; all flags 0.
//   This applies in every state and aborts any division in progress.
//  FSM states: IDLE -> (accept) -> SPECIAL or DIVIDE; DIVIDE (D cycles) -> ROUND -> DONE;
//   SPECIAL -> DONE; DONE -> IDLE when out_ready=1.
//  Accept: in_valid & in_ready at an edge. Operands are registered on that edge.
//   in_ready=1 only in IDLE. in_valid in any other state is ignored.
//  Hidden bit: 1 if exponent!=0, else 0 (denormals are not pre-normalised).
//   ma, mb are 24-bit significands. sign = a[31]^b[31].
//  SPECIAL is taken on accept when Exception, b zero, or a zero. Priority order:
//   1. Exception: result=32'd0
//   2. b zero: result={sign,8'hFF,23'd0}, DivByZero=1
//   3. a zero: result={sign,31'd0}
//  Latency: SPECIAL gives out_valid 2 edges after accept. Normal path gives out_valid D+2 edges after accept.
//  DIVIDE: rem (25b) starts at ma; one quotient bit per step. If rem>=mb then q bit=1 and rem-=mb, else q bit=0.
//   Then rem<<=1. 26 steps fill q[25:0], MSB first; q[25] has weight 2^0.
//  ROUND: exponent arithmetic is 10-bit signed, e = ea - eb + 127.
//   q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0]|(rem!=0).
//   q[25]=0,q[24]=1: mant=q[23:1], guard=q[0], sticky=(rem!=0), e=e-1.
//   q[25:24]=0 (denormal input case): Underflow=1, result={sign,31'd0}.
//   Round-to-nearest-even: mant += guard & (sticky | mant[0]).
//   On mantissa carry-out: mant=0, e=e+1.
//   e>=255: Overflow=1, result={sign,8'hFF,23'd0}. e<=0: Underflow=1, result={sign,31'd0}.
//   Otherwise result={sign,e[7:0],mant}.
//  DONE: result and flags are held stable while out_valid=1 and out_ready=0.
//   On out_ready=1: out_valid falls at that edge, in_ready rises, result is held.
//   Flags are cleared on the next accept.
//  out_ready is don't-care outside DONE.
// CONFIGURATION
//  FP_DIV_IEEE_SPECIALS_EN undefined (default):
//   exception inputs return 32'd0, matching the multiplier's convention.
//  FP_DIV_IEEE_SPECIALS_EN defined: Exception still flags, but result follows IEEE:
//   - NaN on either input, inf/inf, or 0/0 -> 32'h7FC00000
//   - inf/finite -> {sign,8'hFF,23'd0}
//   - finite/inf -> {sign,31'd0}
//   - 0/0 does not assert DivByZero
// TESTING
//  1. 0x40C00000 / 0x40000000 (6/2), QBITS=1 -> result 0x40400000, flags 0, out_valid 28 edges after accept.
//  2. 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (rounds up); repeat with QBITS=2 -> same value, latency 15.
//  3. 0x3F800000 / 0x00000000 -> 0x7F800000, DivByZero=1, latency 2;
//     0x7F800000 / 0x3F800000 -> 0x00000000, Exception=1 (macro off) / 0x7F800000 (macro on).
//  4. 0x7F000000 / 0x00800000 -> 0x7F800000, Overflow=1; 0x00800000 / 0x7F000000 -> 0x00000000, Underflow=1.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0,
//     in_valid pulses ignored; out_ready=1 -> next edge IDLE.
//  6. Drive rst_n=0 for one edge mid-DIVIDE -> next cycle in_ready=1, out_valid=0;
//     a following 6/2 request completes correctly.

Source files
------------

// File: rtl/fp32_divider_seq.sv
// -----------------------------------------------------------------------------
// fp32_divider_seq
//   Iterative IEEE-754 binary32 divider: result = a_operand / b_operand.
//   This is the divide step of the Newton-Raphson datapath, f(x)/f'(x).
//   Restoring division on the 24-bit significands, QBITS_PER_CYCLE quotient
//   bits per cycle. Rounding is round-to-nearest-even. Denormal inputs are
//   not pre-normalised.
//
//   Optional feature macro: FP_DIV_IEEE_SPECIALS_EN
//     undefined : an exception operand (exponent 8'hFF) returns 32'd0
//     defined   : IEEE NaN / inf / zero results for special operands
//
// Parameters
//   QBITS_PER_CYCLE  1 or 2 quotient bits per DIVIDE cycle (26/QBITS cycles)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  idle, operands accepted on in_valid
//   a_operand  in   dividend (FP32)
//   b_operand  in   divisor  (FP32)
//   out_valid  out  result and flags valid
//   out_ready  in   consumer takes the result
//   result     out  quotient (FP32)
//   Exception  out  an operand has exponent 8'hFF
//   Overflow   out  rounded exponent >= 255
//   Underflow  out  rounded exponent <= 0, or quotient not normalisable
//   DivByZero  out  divisor zero with a non-zero, non-exception dividend
// -----------------------------------------------------------------------------
module fp32_divider_seq #(
    parameter int QBITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);

    localparam int         D     = 26 / QBITS_PER_CYCLE;
    localparam logic [4:0] LAST  = 5'(D - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SPECIAL = 3'd1;
    localparam logic [2:0] S_DIVIDE  = 3'd2;
    localparam logic [2:0] S_ROUND   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]  state;
    logic [31:0] a_q, b_q;
    logic [24:0] rem;
    logic [25:0] q;
    logic [4:0]  cnt;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Classification of the incoming operands (decides SPECIAL vs DIVIDE).
    logic in_special;
    always_comb begin
        in_special = (&a_operand[30:23]) | (&b_operand[30:23]) |
                     (a_operand[30:0] == 31'd0) | (b_operand[30:0] == 31'd0);
    end

    // Classification of the registered operands.
    logic        sign;
    logic        a_exc, b_exc, a_zero, b_zero;
    logic [23:0] mb;
    assign sign   = a_q[31] ^ b_q[31];
    assign a_exc  = &a_q[30:23];
    assign b_exc  = &b_q[30:23];
    assign a_zero = (a_q[30:0] == 31'd0);
    assign b_zero = (b_q[30:0] == 31'd0);
    assign mb     = {|b_q[30:23], b_q[22:0]};

    // Special-case result.
    logic [31:0] spec_res;
    logic        spec_dbz;
`ifdef FP_DIV_IEEE_SPECIALS_EN
    logic a_nan, b_nan, a_inf, b_inf;
    assign a_nan = a_exc & (|a_q[22:0]);
    assign b_nan = b_exc & (|b_q[22:0]);
    assign a_inf = a_exc & ~(|a_q[22:0]);
    assign b_inf = b_exc & ~(|b_q[22:0]);
    always_comb begin
        spec_res = {sign, 31'd0};
        spec_dbz = 1'b0;
        if (a_exc | b_exc) begin
            if (a_nan | b_nan | (a_inf & b_inf))
                spec_res = 32'h7FC0_0000;
            else if (a_inf)
                spec_res = {sign, 8'hFF, 23'd0};
            else
                spec_res = {sign, 31'd0};
        end else if (b_zero) begin
            if (a_zero) begin
                spec_res = 32'h7FC0_0000;
            end else begin
                spec_res = {sign, 8'hFF, 23'd0};
                spec_dbz = 1'b1;
            end
        end
    end
`else
    always_comb begin
        spec_res = {sign, 31'd0};
        spec_dbz = 1'b0;
        if (a_exc | b_exc) begin
            spec_res = 32'd0;
        end else if (b_zero) begin
            spec_res = {sign, 8'hFF, 23'd0};
            spec_dbz = ~a_zero;
        end
    end
`endif

    // Restoring division: QBITS_PER_CYCLE compare/subtract/shift steps.
    logic [24:0] step_rem;
    logic [25:0] step_q;
    always_comb begin
        step_rem = rem;
        step_q   = q;
        for (int i = 0; i < QBITS_PER_CYCLE; i++) begin
            if (step_rem >= {1'b0, mb}) begin
                step_q   = {step_q[24:0], 1'b1};
                step_rem = step_rem - {1'b0, mb};
            end else begin
                step_q   = {step_q[24:0], 1'b0};
            end
            step_rem = {step_rem[23:0], 1'b0};
        end
    end

    // Normalise, round to nearest even, range check.
    logic signed [9:0] e0, e1, e2;
    logic [22:0] m, mant;
    logic        g, s;
    logic [23:0] m_rnd;
    logic [31:0] rnd_res;
    logic        rnd_ovf, rnd_unf;
    always_comb begin
        e0 = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
        if (q[25]) begin
            m  = q[24:2];
            g  = q[1];
            s  = q[0] | (|rem);
            e1 = e0;
        end else begin
            m  = q[23:1];
            g  = q[0];
            s  = |rem;
            e1 = e0 - 10'sd1;
        end
        m_rnd = {1'b0, m} + {23'd0, g & (s | m[0])};
        if (m_rnd[23]) begin
            mant = 23'd0;
            e2   = e1 + 10'sd1;
        end else begin
            mant = m_rnd[22:0];
            e2   = e1;
        end
        rnd_ovf = 1'b0;
        rnd_unf = 1'b0;
        rnd_res = {sign, e2[7:0], mant};
        if (q[25:24] == 2'b00) begin
            // Only reachable with a denormal dividend.
            rnd_unf = 1'b1;
            rnd_res = {sign, 31'd0};
        end else if (e2 >= 10'sd255) begin
            rnd_ovf = 1'b1;
            rnd_res = {sign, 8'hFF, 23'd0};
        end else if (e2 <= 10'sd0) begin
            rnd_unf = 1'b1;
            rnd_res = {sign, 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rem       <= 25'd0;
            q         <= 26'd0;
            cnt       <= 5'd0;
            result    <= 32'd0;
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q       <= a_operand;
                        b_q       <= b_operand;
                        rem       <= {1'b0, |a_operand[30:23], a_operand[22:0]};
                        q         <= 26'd0;
                        cnt       <= 5'd0;
                        Exception <= 1'b0;
                        Overflow  <= 1'b0;
                        Underflow <= 1'b0;
                        DivByZero <= 1'b0;
                        state     <= in_special ? S_SPECIAL : S_DIVIDE;
                    end
                end
                S_SPECIAL: begin
                    result    <= spec_res;
                    Exception <= a_exc | b_exc;
                    DivByZero <= ~(a_exc | b_exc) & spec_dbz;
                    state     <= S_DONE;
                end
                S_DIVIDE: begin
                    rem <= step_rem;
                    q   <= step_q;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST)
                        state <= S_ROUND;
                end
                S_ROUND: begin
                    result    <= rnd_res;
                    Overflow  <= rnd_ovf;
                    Underflow <= rnd_unf;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider_seq.sv
module tb_fp32_divider_seq;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a_op = 32'd0;
    logic [31:0] b_op = 32'd0;

    logic        ir1, ov1, exc1, ovf1, unf1, dbz1;
    logic        ir2, ov2, exc2, ovf2, unf2, dbz2;
    logic [31:0] res1, res2;
    logic [3:0]  flg1, flg2;
    assign flg1 = {exc1, ovf1, unf1, dbz1};
    assign flg2 = {exc2, ovf2, unf2, dbz2};

    exp_t q1[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fp32_divider_seq #(.QBITS_PER_CYCLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a_operand(a_op), .b_operand(b_op), .out_valid(ov1), .out_ready(out_ready),
        .result(res1), .Exception(exc1), .Overflow(ovf1), .Underflow(unf1),
        .DivByZero(dbz1));

    fp32_divider_seq #(.QBITS_PER_CYCLE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .a_operand(a_op), .b_operand(b_op), .out_valid(ov2), .out_ready(out_ready),
        .result(res2), .Exception(exc2), .Overflow(ovf2), .Underflow(unf2),
        .DivByZero(dbz2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!(ir1 && ir2) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!(ir1 && ir2)) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_cmp(input string tag, input int which, input logic [31:0] r,
                           input logic [3:0] f, input int cnt);
        exp_t e;
        if (which == 1 && q1.size() == 0) begin check({tag, "_sb_empty"}, 32'd0, 32'd1); return; end
        if (which == 2 && q2.size() == 0) begin check({tag, "_sb_empty"}, 32'd0, 32'd1); return; end
        e = (which == 1) ? q1.pop_front() : q2.pop_front();
        check({tag, "_res"}, r, e.res);
        check({tag, "_flags"}, {28'd0, f}, {28'd0, e.flg});
        check({tag, "_latency"}, cnt, {24'd0, e.lat});
    endtask

    // Push expectations, drive one request, collect both DUTs' results.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic [3:0] f, input bit special);
        int  cnt;
        bit  d1, d2;
        exp_t e;
        wait_idle();
        e.res = r; e.flg = f; e.lat = special ? 8'd2 : 8'd28; q1.push_back(e);
        e.lat = special ? 8'd2 : 8'd15;                     q2.push_back(e);
        a_op = a; b_op = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1; d1 = 0; d2 = 0;
        while (!(d1 && d2) && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
            if (ov1 && !d1) begin pop_cmp({tag, "_q1"}, 1, res1, flg1, cnt); d1 = 1; end
            if (ov2 && !d2) begin pop_cmp({tag, "_q2"}, 2, res2, flg2, cnt); d2 = 1; end
        end
        if (!(d1 && d2)) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin : stim
        int   guard;
        exp_t e;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready1", {31'd0, ir1}, 32'd1);
        check("rst_out_valid1", {31'd0, ov1}, 32'd0);
        check("rst_result1", res1, 32'd0);
        check("rst_flags1", {28'd0, flg1}, 32'd0);
        check("rst_in_ready2", {31'd0, ir2}, 32'd1);
        check("rst_result2", res2, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Normal path
        run_op("6div2",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 1'b0);
        run_op("1div3",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 1'b0);
        run_op("1div1.5", 32'h3F80_0000, 32'h3FC0_0000, 32'h3F2A_AAAB, 4'b0000, 1'b0);
        run_op("n6div2",  32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 1'b0);
        run_op("1div1",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 1'b0);
        run_op("ovf",     32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b0100, 1'b0);
        run_op("unf",     32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0010, 1'b0);
        run_op("denorm",  32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0010, 1'b0);

        // Special path
        run_op("1div0",   32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0001, 1'b1);
        run_op("0div5",   32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 4'b0000, 1'b1);
        run_op("n0div5",  32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 4'b0000, 1'b1);
        run_op("1divinf", 32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 4'b1000, 1'b1);
`ifdef FP_DIV_IEEE_SPECIALS_EN
        run_op("infdiv1", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'b1000, 1'b1);
        run_op("nandiv1", 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1'b1);
        run_op("0div0",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0000, 1'b1);
`else
        run_op("infdiv1", 32'h7F80_0000, 32'h3F80_0000, 32'h0000_0000, 4'b1000, 1'b1);
        run_op("nandiv1", 32'h7FC0_0000, 32'h3F80_0000, 32'h0000_0000, 4'b1000, 1'b1);
        run_op("0div0",   32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0000, 1'b1);
`endif

        // Backpressure: both DUTs sit in DONE while out_ready is low.
        wait_idle();
        out_ready = 1'b0;
        e.res = 32'h4040_0000; e.flg = 4'b0000; e.lat = 8'd0;
        q1.push_back(e); q2.push_back(e);
        a_op = 32'h40C0_0000; b_op = 32'h4000_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!(ov1 && ov2) && guard < 60) begin @(posedge clk); #1; guard++; end
        if (!(ov1 && ov2)) check("bp_timeout", 32'd0, 32'd1);
        e = q1.pop_front(); check("bp_res1", res1, e.res);
        e = q2.pop_front(); check("bp_res2", res2, e.res);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_op = 32'h3F80_0000; b_op = 32'h0000_0000; in_valid = i[0] ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            check("bp_hold_res1", res1, 32'h4040_0000);
            check("bp_hold_flags1", {28'd0, flg1}, 32'd0);
            check("bp_hold_valid1", {31'd0, ov1}, 32'd1);
            check("bp_hold_ready1", {31'd0, ir1}, 32'd0);
            check("bp_hold_res2", res2, 32'h4040_0000);
            check("bp_hold_ready2", {31'd0, ir2}, 32'd0);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_valid1", {31'd0, ov1}, 32'd0);
        check("bp_rel_ready1", {31'd0, ir1}, 32'd1);
        check("bp_rel_res1", res1, 32'h4040_0000);
        check("bp_rel_ready2", {31'd0, ir2}, 32'd1);
        run_op("after_bp", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 1'b0);

        // Reset mid-DIVIDE aborts the division.
        wait_idle();
        a_op = 32'h3F80_0000; b_op = 32'h4040_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_ready1", {31'd0, ir1}, 32'd1);
        check("abort_valid1", {31'd0, ov1}, 32'd0);
        check("abort_ready2", {31'd0, ir2}, 32'd1);
        check("abort_valid2", {31'd0, ov2}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 1'b0);

        check("sb1_drained", q1.size(), 32'd0);
        check("sb2_drained", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
